// File: rtl/mux_2n_to_1_pipe.sv
// Parametrised 2^SEL_W-to-1 word mux tree with optional per-level registers.
// Carries valid and the selected index alongside the data; scan mode walks inputs in order.
module mux_2n_to_1_pipe #(
    parameter int SEL_W  = 5,
    parameter int DATA_W = 1,
    parameter int PIPE   = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    input  logic [DATA_W*(1<<SEL_W)-1:0]   inp,
    input  logic [SEL_W-1:0]               sel,
    input  logic                           scan_en,
    output logic [DATA_W-1:0]              OUT,
    output logic                           out_valid,
    output logic [SEL_W-1:0]               out_sel
);
    localparam int N = 1 << SEL_W;

    logic [SEL_W-1:0] scan_cnt;
    logic [SEL_W-1:0] esel;

    assign esel = scan_en ? scan_cnt : sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
        end else if (in_valid && scan_en) begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    if (PIPE != 0) begin : g_pipe
        // All levels packed into one vector: level j starts at word N - (N >> j)
        // and holds N >> (j+1) words, so the final word is the tree output.
        localparam int TW = DATA_W * (N - 1);

        logic [TW-1:0]    tree_q;
        logic [TW-1:0]    tree_n;
        logic [TW-1:0]    tree_ld;
        logic [SEL_W-1:0] vld_q;
        logic [SEL_W-1:0] vld_in;
        logic [SEL_W-1:0] idx_q  [SEL_W];
        logic [SEL_W-1:0] idx_in [SEL_W];

        always_comb begin
            vld_in    = '0;
            vld_in[0] = in_valid;
            idx_in[0] = esel;
            for (int j = 1; j < SEL_W; j++) begin
                vld_in[j] = vld_q[j-1];
                idx_in[j] = idx_q[j-1];
            end
        end

        always_comb begin
            tree_n  = '0;
            tree_ld = '0;
            for (int i = 0; i < N/2; i++) begin
                tree_n[i*DATA_W +: DATA_W] = esel[0] ? inp[(2*i+1)*DATA_W +: DATA_W]
                                                     : inp[(2*i)*DATA_W +: DATA_W];
            end
            for (int j = 1; j < SEL_W; j++) begin
                for (int i = 0; i < (N >> (j+1)); i++) begin
                    tree_n[(N - (N >> j) + i)*DATA_W +: DATA_W] = idx_q[j-1][j]
                        ? tree_q[(N - (N >> (j-1)) + 2*i + 1)*DATA_W +: DATA_W]
                        : tree_q[(N - (N >> (j-1)) + 2*i)*DATA_W +: DATA_W];
                end
            end
            // A level only loads when a valid sample arrives; bubbles leave it holding.
            for (int j = 0; j < SEL_W; j++) begin
                for (int i = 0; i < (N >> (j+1)); i++) begin
                    tree_ld[(N - (N >> j) + i)*DATA_W +: DATA_W] = {DATA_W{vld_in[j]}};
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                tree_q <= '0;
                vld_q  <= '0;
                for (int j = 0; j < SEL_W; j++) begin
                    idx_q[j] <= '0;
                end
            end else begin
                tree_q <= (tree_n & tree_ld) | (tree_q & ~tree_ld);
                vld_q  <= vld_in;
                for (int j = 0; j < SEL_W; j++) begin
                    if (vld_in[j]) begin
                        idx_q[j] <= idx_in[j];
                    end
                end
            end
        end

        assign OUT       = tree_q[TW-1 -: DATA_W];
        assign out_valid = vld_q[SEL_W-1];
        assign out_sel   = idx_q[SEL_W-1];
    end else begin : g_comb
        logic [DATA_W-1:0] res;
        logic [DATA_W-1:0] out_q;
        logic              vld_q;
        logic [SEL_W-1:0]  idx_q;

        always_comb begin
            logic [DATA_W*N-1:0] red;
            red = inp;
            // In-place halving: word i is written only after words 2i and 2i+1 are read.
            for (int j = 0; j < SEL_W; j++) begin
                for (int i = 0; i < (N >> (j+1)); i++) begin
                    red[i*DATA_W +: DATA_W] = esel[j] ? red[(2*i+1)*DATA_W +: DATA_W]
                                                      : red[(2*i)*DATA_W +: DATA_W];
                end
            end
            res = red[DATA_W-1:0];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_q <= '0;
                vld_q <= 1'b0;
                idx_q <= '0;
            end else begin
                vld_q <= in_valid;
                if (in_valid) begin
                    out_q <= res;
                    idx_q <= esel;
                end
            end
        end

        assign OUT       = out_q;
        assign out_valid = vld_q;
        assign out_sel   = idx_q;
    end
endmodule

// File: tb/tb_mux_2n_to_1_pipe.sv
// Scoreboard bench for mux_2n_to_1_pipe across four parameter sets.
// Stimulus pushes expected results; a negedge monitor pops and compares.
module tb_mux_2n_to_1_pipe;
    localparam int NI = 4;

    typedef struct {
        logic [7:0] d;
        logic [4:0] s;
        int         c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        v_a    [NI];
    logic        scan_a [NI];
    logic [4:0]  sel_a  [NI];
    logic [31:0] inp_a  [NI];

    logic       o0, ov0;
    logic [4:0] s0;
    logic [7:0] o1;
    logic       ov1;
    logic [1:0] s1;
    logic [3:0] o2;
    logic       ov2;
    logic [2:0] s2;
    logic [2:0] o3;
    logic       ov3;
    logic [0:0] s3;

    exp_t       q [NI][$];
    int         scnt   [NI];
    int         n_out  [NI];
    logic [7:0] last_o [NI];
    logic [4:0] last_s [NI];
    int         cyc = 0;
    int         n_chk = 0;
    int         n_pass = 0;

    mux_2n_to_1_pipe #(.SEL_W(5), .DATA_W(1), .PIPE(1)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v_a[0]), .inp(inp_a[0][31:0]),
        .sel(sel_a[0][4:0]), .scan_en(scan_a[0]), .OUT(o0), .out_valid(ov0), .out_sel(s0));
    mux_2n_to_1_pipe #(.SEL_W(2), .DATA_W(8), .PIPE(0)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v_a[1]), .inp(inp_a[1][31:0]),
        .sel(sel_a[1][1:0]), .scan_en(scan_a[1]), .OUT(o1), .out_valid(ov1), .out_sel(s1));
    mux_2n_to_1_pipe #(.SEL_W(3), .DATA_W(4), .PIPE(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v_a[2]), .inp(inp_a[2][31:0]),
        .sel(sel_a[2][2:0]), .scan_en(scan_a[2]), .OUT(o2), .out_valid(ov2), .out_sel(s2));
    mux_2n_to_1_pipe #(.SEL_W(1), .DATA_W(3), .PIPE(0)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(v_a[3]), .inp(inp_a[3][5:0]),
        .sel(sel_a[3][0:0]), .scan_en(scan_a[3]), .OUT(o3), .out_valid(ov3), .out_sel(s3));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sw_of(input int k);
        case (k)
            0: return 5;
            1: return 2;
            2: return 3;
            default: return 1;
        endcase
    endfunction

    function automatic int dw_of(input int k);
        case (k)
            0: return 1;
            1: return 8;
            2: return 4;
            default: return 3;
        endcase
    endfunction

    // PIPE=1 -> one register per level; PIPE=0 -> single output register.
    function automatic int lat_of(input int k);
        case (k)
            0: return 5;
            1: return 1;
            2: return 3;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s at %0t: got=%0h want=%0h", nm, $time, got, want);
    endtask

    task automatic mon(input int k, input logic ov, input logic [7:0] o, input logic [4:0] s);
        exp_t e;
        if (ov) begin
            n_out[k]++;
            chk($sformatf("out_expected_u%0d", k), 64'(q[k].size() != 0), 64'd1);
            if (q[k].size() != 0) begin
                e = q[k].pop_front();
                chk($sformatf("result_u%0d{out,sel,cyc}", k), 64'({o, s, cyc}), 64'({e.d, e.s, e.c}));
            end
            last_o[k] = o;
            last_s[k] = s;
        end else begin
            chk($sformatf("hold_u%0d{out,sel}", k), 64'({o, s}), 64'({last_o[k], last_s[k]}));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, ov0, 8'(o0), s0);
            mon(1, ov1, o1, 5'(s1));
            mon(2, ov2, 8'(o2), 5'(s2));
            mon(3, ov3, 8'(o3), 5'(s3));
        end
    end

    // Reference: result is word esel of the sampled input; scan index counts accepted scan samples.
    task automatic push_model();
        int   es;
        exp_t e;
        for (int k = 0; k < NI; k++) begin
            if (v_a[k]) begin
                es  = scan_a[k] ? scnt[k] : int'(sel_a[k]) % (1 << sw_of(k));
                e.d = 8'((inp_a[k] >> (es * dw_of(k))) & ((32'd1 << dw_of(k)) - 32'd1));
                e.s = 5'(es);
                e.c = cyc + lat_of(k);
                q[k].push_back(e);
                if (scan_a[k]) scnt[k] = (scnt[k] + 1) % (1 << sw_of(k));
            end
        end
    endtask

    task automatic step();
        push_model();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < NI; k++) v_a[k] = 1'b0;
        repeat (n) step();
    endtask

    task automatic drive(input int k, input logic v, input logic sc, input int s, input logic [31:0] d);
        for (int m = 0; m < NI; m++) v_a[m] = 1'b0;
        v_a[k]    = v;
        scan_a[k] = sc;
        sel_a[k]  = 5'(s);
        inp_a[k]  = d;
        step();
    endtask

    task automatic clear_model();
        for (int k = 0; k < NI; k++) begin
            q[k].delete();
            scnt[k]   = 0;
            last_o[k] = '0;
            last_s[k] = '0;
        end
    endtask

    initial begin
        int base;
        for (int k = 0; k < NI; k++) begin
            v_a[k] = 1'b0; scan_a[k] = 1'b0; sel_a[k] = '0; inp_a[k] = '0;
            n_out[k] = 0;
        end
        clear_model();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_out_u0", 64'(o0), 64'd0);
        chk("reset_valid_u0", 64'(ov0), 64'd0);
        chk("reset_sel_u0", 64'(s0), 64'd0);
        chk("reset_out_u1", 64'(o1), 64'd0);

        // Basic select on the 32-to-1 pipelined tree.
        base = n_out[0];
        drive(0, 1'b1, 1'b0, 31, 32'hABCD_EF12);
        drive(0, 1'b1, 1'b0, 0,  32'hABCD_EF12);
        drive(0, 1'b1, 1'b0, 1,  32'hABCD_EF12);
        idle(8);
        chk("basic_count", 64'(n_out[0] - base), 64'd3);
        chk("basic_last", 64'({last_o[0], last_s[0]}), 64'({8'd1, 5'd1}));

        // Wide words, combinational tree.
        base = n_out[1];
        drive(1, 1'b1, 1'b0, 2, 32'h4433_2211);
        drive(1, 1'b1, 1'b0, 3, 32'h4433_2211);
        idle(3);
        chk("wide_count", 64'(n_out[1] - base), 64'd2);
        chk("wide_last", 64'({last_o[1], last_s[1]}), 64'({8'h44, 5'd3}));

        // Scan walk with wrap on the 33rd sample.
        base = n_out[0];
        repeat (33) drive(0, 1'b1, 1'b1, 0, 32'hABCD_EF12);
        idle(8);
        chk("scan_count", 64'(n_out[0] - base), 64'd33);
        chk("scan_wrap", 64'({last_o[0], last_s[0]}), 64'({8'd0, 5'd0}));

        // Bubbles.
        base = n_out[0];
        drive(0, 1'b1, 1'b0, 3, 32'hABCD_EF12);
        drive(0, 1'b0, 1'b0, 9, 32'hABCD_EF12);
        drive(0, 1'b1, 1'b0, 5, 32'hABCD_EF12);
        drive(0, 1'b1, 1'b0, 7, 32'hABCD_EF12);
        drive(0, 1'b0, 1'b0, 2, 32'hABCD_EF12);
        idle(8);
        chk("bubble_count", 64'(n_out[0] - base), 64'd3);
        chk("bubble_last", 64'({last_o[0], last_s[0]}), 64'({8'd0, 5'd7}));

        // Reset with three samples in flight.
        repeat (3) drive(0, 1'b1, 1'b1, 0, 32'hFFFF_FFFF);
        for (int k = 0; k < NI; k++) v_a[k] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out", 64'(o0), 64'd0);
        chk("midrst_valid", 64'(ov0), 64'd0);
        chk("midrst_sel", 64'(s0), 64'd0);
        clear_model();
        @(negedge clk);
        #2 rst_n = 1'b1;
        base = n_out[0];
        idle(8);
        chk("midrst_no_stale", 64'(n_out[0] - base), 64'd0);
        drive(0, 1'b1, 1'b1, 0, 32'h0000_0001);
        idle(8);
        chk("midrst_scan_restart", 64'({last_o[0], last_s[0]}), 64'({8'd1, 5'd0}));

        // Random regression on all four configurations.
        repeat (1000) begin
            for (int k = 0; k < NI; k++) begin
                v_a[k]    = ($urandom_range(0, 3) != 0);
                scan_a[k] = ($urandom_range(0, 1) == 1);
                sel_a[k]  = 5'($urandom_range(0, (1 << sw_of(k)) - 1));
                inp_a[k]  = $urandom;
            end
            step();
        end
        idle(10);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("drained_u%0d", k), 64'(q[k].size()), 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
